// File: rtl/lc_target_seq.sv
// lc_target_seq: lifecycle target sequencer.
//
// Holds a small table of encoded lifecycle state codes and, on request,
// streams the first `len` entries out over a valid/ready port, followed by
// a one-cycle done pulse. The table is writable only while the block is idle.
//
// Optional feature: define LC_TARGET_SEQ_CNT_EN to add the 16-bit saturating
// xfer_cnt output that counts accepted handshakes since reset.
//
// Handshake rule for the tgt_* port: the producer raises tgt_valid with
// tgt_data/tgt_idx and keeps all three stable until a rising clk edge sees
// tgt_valid && tgt_ready; that edge is the transfer. tgt_valid never depends
// combinationally on tgt_ready.

module lc_target_seq #(
  parameter int STATE_W = 6,
  parameter int NUM_TGT = 5,
  parameter int IDX_W   = $clog2(NUM_TGT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [STATE_W-1:0] wr_data,
  input  logic               start,
  input  logic [IDX_W:0]     len,
  output logic               tgt_valid,
  input  logic               tgt_ready,
  output logic [STATE_W-1:0] tgt_data,
  output logic [IDX_W-1:0]   tgt_idx,
  output logic               busy,
  output logic               done,
  output logic               err,
`ifdef LC_TARGET_SEQ_CNT_EN
  output logic [15:0]        xfer_cnt,
`endif
  input  logic               err_clr
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------

  // FSM encoding. Code 2'd3 is unused and recovers to IDLE.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Table size expressed at index-plus-one width so range checks on wr_idx
  // and len compare equal-width operands (NUM_TGT itself may be 2**IDX_W).
  localparam logic [IDX_W:0]   NUM_TGT_L = NUM_TGT[IDX_W:0];
  localparam logic [IDX_W:0]   LEN_ONE   = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------

  logic [1:0]                          state;
  logic [1:0]                          state_nxt;
  logic [IDX_W-1:0]                    idx;
  logic [IDX_W:0]                      len_q;
  logic [NUM_TGT-1:0][STATE_W-1:0]     table_q;

  // --------------------------------------------------------------------------
  // Decoded conditions
  // --------------------------------------------------------------------------

  logic is_idle;
  logic is_run;
  logic is_done;
  logic len_ok;
  logic start_ok;
  logic start_bad;
  logic wr_in_range;
  logic wr_ok;
  logic wr_bad;
  logic err_set;
  logic hs;
  logic last;

  assign is_idle = (state == S_IDLE);
  assign is_run  = (state == S_RUN);
  assign is_done = (state == S_DONE);

  // A start request is only meaningful in IDLE; while busy it is silently
  // dropped (no error).
  assign len_ok    = (len != '0) && (len <= NUM_TGT_L);
  assign start_ok  = is_idle && start && len_ok;
  assign start_bad = is_idle && start && !len_ok;

  // Writes land only in IDLE and only on an existing entry. Anything else is
  // dropped and flagged.
  assign wr_in_range = ({1'b0, wr_idx} < NUM_TGT_L);
  assign wr_ok       = wr_en && is_idle && wr_in_range;
  assign wr_bad      = wr_en && !wr_ok;

  assign err_set = start_bad || wr_bad;

  // Transfer on the tgt_* port, and whether it is the final entry.
  assign hs   = is_run && tgt_ready;
  assign last = ({1'b0, idx} == (len_q - LEN_ONE));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------

  // Next-state selection: IDLE -> RUN on a valid start, RUN -> DONE on the
  // final transfer, DONE always returns to IDLE after one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (hs && last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sequence bookkeeping: latch the requested length on start, advance the
  // index on each non-final transfer, park the index at 0 on the way out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      len_q <= '0;
    end else begin
      if (start_ok) begin
        len_q <= len;
        idx   <= '0;
      end else if (hs && !last) begin
        idx <= idx + IDX_ONE;
      end else if (is_done) begin
        idx <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Target table
  // --------------------------------------------------------------------------

  // Entry k resets to k (truncated to STATE_W). Accepted writes update one
  // entry on the same edge. Because the run reads the table live and starts
  // reading one cycle after the start edge, a write accepted together with a
  // start is already visible to the run it launches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_TGT; k++) begin
        table_q[k] <= STATE_W'(k);
      end
    end else if (wr_ok) begin
      table_q[wr_idx] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Error flag
  // --------------------------------------------------------------------------

  // Sticky error; a new error in the same cycle as err_clr keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------

  // All outputs derive from registers only. The table cannot change while a
  // run is in progress, so table_q[idx] is stable for as long as idx is.
  always_comb begin
    tgt_valid = is_run;
    tgt_idx   = idx;
    tgt_data  = is_run ? table_q[idx] : '0;
    busy      = is_run || is_done;
    done      = is_done;
  end

`ifdef LC_TARGET_SEQ_CNT_EN
  // Count accepted transfers since reset, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (hs && (xfer_cnt != 16'hFFFF)) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lc_target_seq.sv
// tb_lc_target_seq: directed plus randomized bench for lc_target_seq.
// The reference model is a plain array of table contents, a sticky error
// bit and a transfer count; expected streams are built as queues of entries.

module tb_lc_target_seq;

  localparam int NT = 5;
  localparam int SW = 6;
  localparam int IW = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic [SW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [IW:0]   len = '0;
  logic          tgt_ready = 1'b0;
  logic          err_clr = 1'b0;
  logic          tgt_valid;
  logic [SW-1:0] tgt_data;
  logic [IW-1:0] tgt_idx;
  logic          busy;
  logic          done;
  logic          err;
`ifdef LC_TARGET_SEQ_CNT_EN
  logic [15:0]   xfer_cnt;
`endif

  always #5 clk = ~clk;

  lc_target_seq #(.STATE_W(SW), .NUM_TGT(NT)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .start     (start),
    .len       (len),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_data  (tgt_data),
    .tgt_idx   (tgt_idx),
    .busy      (busy),
    .done      (done),
    .err       (err),
`ifdef LC_TARGET_SEQ_CNT_EN
    .xfer_cnt  (xfer_cnt),
`endif
    .err_clr   (err_clr)
  );

  // ---------------- reference model ----------------
  logic [SW-1:0] m_tbl [NT];
  logic          m_err;
  int            m_cnt;

  int n_cmp = 0;
  int n_err = 0;

  task automatic m_reset();
    for (int k = 0; k < NT; k++) m_tbl[k] = SW'(k);
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (enter and leave at a negedge) ----------------
  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; tgt_ready = 1'b0; err_clr = 1'b0;
    #1;
    chk("rst_valid", tgt_valid, 0);
    chk("rst_data", tgt_data, 0);
    chk("rst_idx", tgt_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic write_entry(input int i, input logic [SW-1:0] d);
    wr_en = 1'b1; wr_idx = IW'(i); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (i < NT) m_tbl[i] = d;
    else m_err = 1'b1;
    chk("wr_err", err, m_err);
    chk("wr_busy", busy, 0);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err = 1'b0;
    chk("clr_err", err, m_err);
  endtask

  task automatic bad_start(input int n);
    start = 1'b1; len = (IW+1)'(n);
    @(negedge clk);
    start = 1'b0;
    m_err = 1'b1;
    chk("bad_start_err", err, m_err);
    chk("bad_start_busy", busy, 0);
  endtask

  // rmode: 0 = ready held high, 1 = ready toggling 0/1, 2 = random ready.
  task automatic run_seq(input int n, input int rmode, input bit wr_mid, input bit st_mid,
                         input bit sw, input int sw_i, input logic [SW-1:0] sw_d);
    logic [SW-1:0] exp_q[$];
    int  pos;
    int  guard;
    int  busy_cyc;
    bit  rdy;
    start = 1'b1; len = (IW+1)'(n);
    if (sw) begin wr_en = 1'b1; wr_idx = IW'(sw_i); wr_data = sw_d; end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    if (sw) m_tbl[sw_i] = sw_d;
    exp_q = {};
    for (int k = 0; k < n; k++) exp_q.push_back(m_tbl[k]);
    pos = 0; guard = 0; busy_cyc = 0;
    while (pos < n && guard < 400) begin
      guard++;
      chk("run_valid", tgt_valid, 1);
      chk("run_idx", tgt_idx, pos);
      chk("run_data", tgt_data, exp_q[pos]);
      chk("run_done", done, 0);
      if (busy) busy_cyc++;
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = (guard % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tgt_ready = rdy;
      if (wr_mid && pos == 1) begin
        wr_en = 1'b1; wr_idx = IW'($urandom_range(0, NT - 1)); wr_data = SW'($urandom);
        m_err = 1'b1;
      end
      if (st_mid) begin
        start = 1'b1; len = (IW+1)'($urandom_range(1, NT));
      end
      @(negedge clk);
      wr_en = 1'b0; start = 1'b0;
      if (rdy) begin pos++; m_cnt++; end
      chk("run_err", err, m_err);
    end
    chk("run_complete", pos, n);
    tgt_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_valid", tgt_valid, 0);
    chk("done_busy", busy, 1);
    if (busy) busy_cyc++;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", tgt_valid, 0);
    if (rmode == 0) chk("busy_cycles", busy_cyc, n + 1);
`ifdef LC_TARGET_SEQ_CNT_EN
    chk("xfer_cnt", xfer_cnt, m_cnt);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random steps ----------------
  initial begin
    #2;
    do_reset();

    // Reset table streams 0..4 with ready held high.
    run_seq(5, 0, 1'b0, 1'b0, 1'b0, 0, '0);

    // Overwrite entry 2, then stream 3 entries with toggling ready.
    write_entry(2, 6'h3F);
    run_seq(3, 1, 1'b0, 1'b0, 1'b0, 0, '0);

    // Illegal requests flag err and leave the table untouched.
    do_reset();
    bad_start(0);
    clear_err();
    bad_start(NT + 1);
    clear_err();
    write_entry(5, 6'h2A);
    // Clear and a new error in the same cycle: set wins.
    err_clr = 1'b1; start = 1'b1; len = '0;
    @(negedge clk);
    err_clr = 1'b0; start = 1'b0;
    chk("set_wins_err", err, m_err);
    clear_err();
    run_seq(5, 0, 1'b0, 1'b0, 1'b0, 0, '0);

    // Write during a run is dropped and flags err; start during run ignored.
    run_seq(4, 0, 1'b1, 1'b1, 1'b0, 0, '0);
    clear_err();
    run_seq(5, 2, 1'b0, 1'b0, 1'b0, 0, '0);

    // Reset at the second handshake of a len=4 run.
    write_entry(1, 6'h15);
    start = 1'b1; len = 4'd4; tgt_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_idx0", tgt_idx, 0);
    @(negedge clk);
    chk("pre_rst_idx1", tgt_idx, 1);
    chk("pre_rst_data1", tgt_data, m_tbl[1]);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", tgt_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_data", tgt_data, 0);
    @(negedge clk);
    chk("mid_rst_done2", done, 0);
    rst = 1'b0; tgt_ready = 1'b0;
    m_reset();
    @(negedge clk);
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    run_seq(5, 0, 1'b0, 1'b0, 1'b0, 0, '0);

    // Write together with start: the run emits the new entry.
    run_seq(3, 0, 1'b0, 1'b0, 1'b1, 0, 6'h2C);

    // Randomized mix of writes, error clears and runs.
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 2; w++) begin
        write_entry($urandom_range(0, NT + 1), SW'($urandom));
      end
      if ($urandom_range(0, 1) == 1) clear_err();
      run_seq($urandom_range(1, NT), 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, NT - 1), SW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lc_target_seq.md
LC_TARGET_SEQ -- requirements
Module: lc_target_seq

Interface
REQ-001 SHALL have parameter STATE_W, default 6, meaning width of one encoded lifecycle state.
REQ-002 SHALL have parameter NUM_TGT, default 5, range 2..64, meaning number of entries in the target table.
REQ-003 SHALL have derived parameter IDX_W = $clog2(NUM_TGT), meaning width of a table index.
REQ-004 SHALL have port clk  in  1  meaning sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port wr_en  in  1  meaning table write strobe.
REQ-007 SHALL have port wr_idx  in  IDX_W  meaning table entry to write.
REQ-008 SHALL have port wr_data  in  STATE_W  meaning state code to write.
REQ-009 SHALL have port start  in  1  meaning begin a sequence.
REQ-010 SHALL have port len  in  IDX_W+1  meaning number of entries to emit, sampled with start.
REQ-011 SHALL have port tgt_valid  out  1  meaning tgt_data and tgt_idx are valid.
REQ-012 SHALL have port tgt_ready  in  1  meaning consumer accepts the current target.
REQ-013 SHALL have port tgt_data  out  STATE_W  meaning current target state code.
REQ-014 SHALL have port tgt_idx  out  IDX_W  meaning table index of current target.
REQ-015 SHALL have port busy  out  1  meaning state is RUN or DONE.
REQ-016 SHALL have port done  out  1  meaning one-cycle sequence-complete pulse.
REQ-017 SHALL have port err  out  1  meaning sticky error flag.
REQ-018 SHALL have port err_clr  in  1  meaning clear err.

Function
REQ-019 SHALL hold a packed table of NUM_TGT entries, each STATE_W bits wide; entry k resets to k mod 2^STATE_W.
REQ-020 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-021 IDLE: start with 1 <= len <= NUM_TGT SHALL latch len, clear the index to 0 and enter RUN on the next edge.
REQ-022 IDLE: start with len==0 or len>NUM_TGT SHALL remain in IDLE and set err.
REQ-023 RUN: tgt_valid SHALL be 1 and tgt_data SHALL equal table[tgt_idx], registered, with no combinational path from tgt_ready.
REQ-024 RUN: tgt_valid, tgt_data and tgt_idx SHALL hold stable until tgt_valid && tgt_ready.
REQ-025 RUN: on handshake at index len-1 SHALL enter DONE; otherwise SHALL increment the index by 1.
REQ-026 DONE: done SHALL be 1 for exactly one cycle, tgt_valid SHALL be 0, and the next state SHALL be IDLE.
REQ-027 Min latency: start to first tgt_valid SHALL be 1 cycle; a len=N sequence with tgt_ready held 1 SHALL complete in N+2 cycles from start to IDLE.
REQ-028 A write in IDLE with wr_idx < NUM_TGT SHALL update the entry on that edge.
REQ-029 A write with wr_idx >= NUM_TGT, or any write while busy, SHALL be ignored and SHALL set err.
REQ-030 start while busy SHALL be ignored without error.
REQ-031 Simultaneous write and valid start in IDLE: both SHALL take effect, and the run SHALL emit the updated entry.
REQ-032 err SHALL clear on err_clr; if a new error occurs in the same cycle, set SHALL win.

Reset
REQ-033 While rst is asserted, outputs SHALL be tgt_valid=0, tgt_data=0, tgt_idx=0, busy=0, done=0, err=0, and the table SHALL reinitialise per REQ-019.
REQ-034 Reset asserted mid-RUN SHALL abort immediately with no done pulse.

Configuration
REQ-035 Macro LC_TARGET_SEQ_CNT_EN, when defined, SHALL add port xfer_cnt out 16, which counts accepted handshakes since reset and saturates at 16'hFFFF with reset value 0.
REQ-036 Without LC_TARGET_SEQ_CNT_EN, the xfer_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-037 Reset, then start with len=5 and tgt_ready=1 -> tgt_data 0,1,2,3,4 on consecutive cycles, done pulses once, and busy is high for 6 cycles.
REQ-038 Write idx 2 = 6'h3F, then start with len=3 and tgt_ready toggling 0/1 -> emitted sequence 0,1,3F, with data stable while ready=0.
REQ-039 start with len=0, then wr_idx=5 with NUM_TGT=5 -> err=1, the table is unchanged, and err_clr returns err to 0.
REQ-040 A write during RUN -> the write is ignored and err=1; the sequence completes normally.
REQ-041 rst asserted at the second handshake of a len=4 run -> immediate IDLE with no done pulse, and the table is back to 0..4.
REQ-042 With LC_TARGET_SEQ_CNT_EN, two len=5 runs -> xfer_cnt=10.
